// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte-stream requesters.
//   Round-robin grant at message granularity: the granted requester keeps the
//   transmitter until it sends a byte flagged last, so messages never
//   interleave. Arbitration takes one cycle in IDLE; each byte then goes
//   ISSUE -> WAIT_BUSY -> WAIT_DONE.
//
//   Optional macro UART_ARB_TIMEOUT_EN: revoke a lock whose holder has left
//   req_valid low for LOCK_TIMEOUT idle cycles in ISSUE (pulses timeout_evt).
//   Without it timeout_evt is tied 0 and a lock is held until req_last.
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   req_valid      per requester: a byte is offered on req_data[8i+:8]
//   req_last       per requester: the offered byte ends its message
//   req_data       packed request bytes
//   req_ready      one-hot pulse: requester's byte consumed this cycle
//   uart_tx_en     one-cycle send strobe to uart_tx
//   uart_tx_data   byte to send, valid with uart_tx_en
//   uart_tx_busy   transmitter busy
//   grant_valid    a requester holds the lock
//   grant_id       index of the lock holder
//   timeout_evt    one-cycle pulse on lock revocation
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_busy,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout_evt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              grant_valid_q, grant_valid_d;
  logic              last_flag_q, last_flag_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   cand;
  logic              issue;
  logic              to_hit;

  // Round-robin search starting just after rr_ptr. Iterating from the farthest
  // candidate down lets the nearest valid requester overwrite earlier hits.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // A byte is handed over only when the transmitter is idle and the holder
  // is offering one; reset masks it so outputs are quiet during reset.
  assign issue = (state_q == ISSUE) && !reset && !uart_tx_busy &&
                 req_valid[grant_id_q];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign to_hit = (state_q == ISSUE) && !reset && (to_cnt_q == TO_W'(LOCK_TIMEOUT));

  // Counts only idle ISSUE cycles; holds while the transmitter is busy and
  // clears on any issue or once ISSUE is left.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ISSUE && !issue && !to_hit) begin
      if (uart_tx_busy) to_cnt_d = to_cnt_q;
      else              to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    last_flag_d   = last_flag_q;
    uart_tx_en    = 1'b0;
    uart_tx_data  = '0;
    req_ready     = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          uart_tx_en            = 1'b1;
          uart_tx_data          = req_data[8*grant_id_q +: 8];
          req_ready[grant_id_q] = 1'b1;
          last_flag_d           = req_last[grant_id_q];
          state_d               = WAIT_BUSY;
        end else if (to_hit) begin
          rr_ptr_d      = grant_id_q;
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (last_flag_q) begin
            rr_ptr_d      = grant_id_q;
            grant_valid_d = 1'b0;
            state_d       = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      last_flag_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      last_flag_q   <= last_flag_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign timeout_evt = to_hit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Scoreboard bench for uart_tx_arbiter: expected (id, byte) pairs are queued
//   as requester bytes are offered and compared at each uart_tx_en. A second
//   instance with NUM_REQ=2 covers the two-requester alternation case.
//   Honours UART_ARB_TIMEOUT_EN (LOCK_TIMEOUT=8 when defined).
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int NR       = 4;
  localparam int BUSY_CYC = 5;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int LT = 8;
`else
  localparam int LT = 1000000;
`endif

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- 4-requester instance ----------------
  logic [NR-1:0]   req_valid, req_last, req_ready;
  logic [8*NR-1:0] req_data;
  logic            uart_tx_en, uart_tx_busy, grant_valid, timeout_evt;
  logic [7:0]      uart_tx_data;
  logic [1:0]      grant_id;
  logic            busy_model, busy_force;
  assign uart_tx_busy = busy_model | busy_force;

  uart_tx_arbiter #(.NUM_REQ(NR), .ID_W(2), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .timeout_evt(timeout_evt)
  );

  // ---------------- 2-requester instance ----------------
  logic [1:0]  d2_valid, d2_last, d2_ready;
  logic [15:0] d2_data;
  logic        d2_en, d2_busy, d2_gv, d2_to;
  logic [7:0]  d2_txd;
  logic [0:0]  d2_gid;

  uart_tx_arbiter #(.NUM_REQ(2), .ID_W(1), .LOCK_TIMEOUT(LT)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(d2_valid), .req_last(d2_last), .req_data(d2_data),
    .req_ready(d2_ready),
    .uart_tx_en(d2_en), .uart_tx_data(d2_txd),
    .uart_tx_busy(d2_busy),
    .grant_valid(d2_gv), .grant_id(d2_gid),
    .timeout_evt(d2_to)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- requester sources ----------------
  logic [8:0] src_mem [NR][32];
  int         src_head [NR] = '{default: 0};
  int         src_tail [NR] = '{default: 0};
  exp_t       exp_q[$];

  task automatic push_src(input int id, input logic [7:0] d, input logic last);
    src_mem[id][src_tail[id]] = {last, d};
    src_tail[id]++;
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Present each requester's queue head; advance after its req_ready pulse.
  initial begin : drv
    logic [NR-1:0] cons;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      cons = req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (cons[i] && src_head[i] < src_tail[i]) src_head[i]++;
        if (src_head[i] < src_tail[i]) begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = src_mem[i][src_head[i]][7:0];
          req_last[i]       = src_mem[i][src_head[i]][8];
        end else begin
          req_valid[i]      = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]       = 1'b0;
        end
      end
    end
  end

  // Transmitter model: busy for BUSY_CYC cycles starting after each send strobe.
  initial begin : busy_gen
    busy_model = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_tx_en) begin
        @(posedge clk);
        #1 busy_model = 1'b1;
        repeat (BUSY_CYC) @(posedge clk);
        #1 busy_model = 1'b0;
      end
    end
  end

  int en_cnt  = 0;
  int rdy_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (req_ready != '0) rdy_cnt++;
    if (uart_tx_en) begin
      en_cnt++;
      check("en_while_busy", uart_tx_busy, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_en_queue", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", uart_tx_data, e.data);
        check("tx_ready", req_ready, 32'(1) << e.id);
        check("tx_grant_id", grant_id, e.id);
        check("tx_grant_valid", grant_valid, 1);
      end
    end else begin
      check("ready_without_en", req_ready, 0);
    end
  end

  // Second instance: its own transmitter model and scoreboard.
  exp_t exp2_q[$];
  int   g2_n       = 0;
  bit   d2_r0_seen = 1'b0;

  initial begin : busy2_gen
    d2_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (d2_en) begin
        @(posedge clk);
        #1 d2_busy = 1'b1;
        repeat (BUSY_CYC) @(posedge clk);
        #1 d2_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e2;
    if (d2_en) begin
      g2_n++;
      if (d2_ready[0]) d2_r0_seen = 1'b1;
      if (exp2_q.size() > 0) begin
        e2 = exp2_q.pop_front();
        check("d2_grant_id", d2_gid, e2.id);
        check("d2_data", d2_txd, e2.data);
      end
    end
  end

  // Wait until all expected bytes are sent and the transmitter is idle again.
  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy_model) && n < budget) begin
      @(posedge clk);
      #3;
      n++;
    end
    check({tag, "_left_in_queue"}, exp_q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int en0, n, evt_at, evt_cnt;
    exp_t e2;
    busy_force = 1'b0;
    d2_valid   = '0;
    d2_last    = '0;
    d2_data    = '0;
    reset      = 1'b1;
    repeat (3) tick();

    // ---- reset state ----
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_en", uart_tx_en, 0);
    check("rst_tx_data", uart_tx_data, 0);
    check("rst_timeout_evt", timeout_evt, 0);
    check("rst_d2_grant_valid", d2_gv, 0);
    reset = 1'b0;
    tick();

    // ---- T1: all four valid, single-byte messages, round robin ----
    for (int i = 0; i < NR; i++) begin
      push_src(i, 8'h10 + 8'(i), 1'b1);
      push_exp(i, 8'h10 + 8'(i));
    end
    push_src(0, 8'h10, 1'b1);
    push_exp(0, 8'h10);
    wait_drain("t1", 300);
    check("t1_en_count", en_cnt, 5);
    check("t1_ready_count", rdy_cnt, 5);

    // ---- T2: 3-byte message from 2 locks out requester 0 ----
    push_src(2, 8'hA0, 1'b0);
    push_src(2, 8'hA1, 1'b0);
    push_src(2, 8'hA2, 1'b1);
    push_src(0, 8'h55, 1'b1);
    push_exp(2, 8'hA0);
    push_exp(2, 8'hA1);
    push_exp(2, 8'hA2);
    push_exp(0, 8'h55);
    wait_drain("t2", 300);

    // ---- T3: busy already high at grant ----
    busy_force = 1'b1;
    push_src(1, 8'h77, 1'b1);
    push_exp(1, 8'h77);
    en0 = en_cnt;
    repeat (10) tick();
    check("t3_en_while_forced", en_cnt - en0, 0);
    check("t3_grant_valid", grant_valid, 1);
    check("t3_grant_id", grant_id, 1);
    busy_force = 1'b0;
    @(negedge clk);
    check("t3_en_on_release", uart_tx_en, 1);
    wait_drain("t3", 100);

    // ---- T4: reset while waiting for the transmitter ----
    push_src(1, 8'h21, 1'b0);
    push_exp(1, 8'h21);
    en0 = en_cnt;
    n   = 0;
    while (en_cnt == en0 && n < 50) begin
      tick();
      n++;
    end
    check("t4_first_byte_sent", en_cnt - en0, 1);
    tick();
    reset = 1'b1;
    tick();
    check("t4_grant_valid", grant_valid, 0);
    check("t4_req_ready", req_ready, 0);
    check("t4_tx_en", uart_tx_en, 0);
    reset = 1'b0;
    push_src(3, 8'h63, 1'b1);
    push_src(0, 8'h60, 1'b1);
    push_exp(0, 8'h60);
    push_exp(3, 8'h63);
    wait_drain("t4", 200);

    // ---- T5: holder drops valid mid-message ----
    push_src(1, 8'h91, 1'b0);
    push_src(2, 8'hB2, 1'b1);
    push_exp(1, 8'h91);
    push_exp(2, 8'hB2);
    n = 0;
    while (!busy_model && n < 50) begin
      @(posedge clk);
      #3;
      n++;
    end
    n = 0;
    while (busy_model && n < 50) begin
      @(posedge clk);
      #3;
      n++;
    end
    check("t5_busy_released", busy_model, 0);
`ifdef UART_ARB_TIMEOUT_EN
    // Next negedge is the final WAIT_DONE cycle; ISSUE cycle j is index j+1.
    evt_at  = -1;
    evt_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (timeout_evt) begin
        evt_cnt++;
        if (evt_at < 0) evt_at = k;
      end
    end
    check("t5_timeout_cycle", evt_at, LT + 1);
    check("t5_timeout_pulses", evt_cnt, 1);
    tick();
    wait_drain("t5", 200);
`else
    evt_at  = 0;
    evt_cnt = 0;
    en0     = en_cnt;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (timeout_evt) evt_cnt++;
      if (grant_valid && grant_id == 2'd1) evt_at++;
    end
    check("t5_timeout_pulses", evt_cnt, 0);
    check("t5_lock_held_cycles", evt_at, 100);
    check("t5_no_bytes_while_locked", en_cnt - en0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_drain("t5", 200);
`endif

    // ---- T6: two requesters, 1 continuously valid, 0 asserts once ----
    d2_last  = 2'b11;
    d2_data  = {8'hC1, 8'hC0};
    d2_valid = 2'b10;
    e2.id = 2'd1; e2.data = 8'hC1; exp2_q.push_back(e2);
    n = 0;
    while (g2_n < 1 && n < 50) begin
      tick();
      n++;
    end
    d2_valid[0] = 1'b1;
    e2.id = 2'd0; e2.data = 8'hC0; exp2_q.push_back(e2);
    e2.id = 2'd1; e2.data = 8'hC1; exp2_q.push_back(e2);
    n = 0;
    while (!d2_r0_seen && n < 100) begin
      tick();
      n++;
    end
    d2_valid[0] = 1'b0;
    n = 0;
    while (g2_n < 3 && n < 100) begin
      tick();
      n++;
    end
    d2_valid = 2'b00;
    check("t6_grants_seen", g2_n, 3);
    check("t6_queue_left", exp2_q.size(), 0);
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
